// File: rtl/b8_ifu_pkg.sv
// b8_ifu_pkg: shared types and constants for the IFU issue queue.
package b8_ifu_pkg;
    typedef logic [1:0] pid_t;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] addr;
    } issue_entry_t;
    localparam int ISSUE_DEPTH = 4;
    localparam int MAX_INFLIGHT = 4;
endpackage

// File: rtl/ifu_issue_queue_sync_fifo.sv
// SyncFifo: parameterised synchronous FIFO with extra-bit pointers and a clear port.
module SyncFifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = wptr == rptr;
    assign rdata = mem[rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rptr <= wptr;
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
        end
    end
endmodule

// File: rtl/ifu_issue_queue.sv
// ifu_issue_queue: buffers fetched words, issues them to the way0 decoder with rotating pIDs
// and tracks in-flight pIDs until in-order retirement.
module ifu_issue_queue
    import b8_ifu_pkg::*;
#(
    parameter int DEPTH = ISSUE_DEPTH,
    parameter int MAX_INFLIGHT = b8_ifu_pkg::MAX_INFLIGHT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetchValid_i,
    input  logic [31:0] fetchInst_i,
    input  logic [31:0] fetchAddr_i,
    output logic        fetchReady_o,
    input  logic        flush_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instAddr_o,
    output logic [1:0]  way0_pID_o,
    input  logic        ready_i,
    input  logic        retireValid_i,
    input  logic [1:0]  retirePid_i,
    output logic [2:0]  inflight_o,
    output logic        retireErr_o
);
    issue_entry_t head, wentry;
    logic full, empty, push, issue, retire_ok, retire_bad;
    logic [2:0] inflight;
    pid_t next_pid, oldest_pid;
    assign wentry = '{inst: fetchInst_i, addr: fetchAddr_i};
    assign fetchReady_o = !full;
    assign valid_o = !empty && (inflight < 3'(MAX_INFLIGHT));
    assign push = fetchValid_i && fetchReady_o;
    assign issue = valid_o && ready_i;
    assign retire_ok = retireValid_i && (inflight != 3'd0);
    assign retire_bad = retireValid_i && ((inflight == 3'd0) || (retirePid_i != oldest_pid));
    assign inst_o = head.inst;
    assign instAddr_o = head.addr;
    assign way0_pID_o = next_pid;
    assign inflight_o = inflight;
    SyncFifo #(.WIDTH($bits(issue_entry_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (issue),
        .clear (flush_i),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );
    // A mismatched retire still advances the oldest pointer so tracking stays in step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            next_pid <= '0;
            oldest_pid <= '0;
            retireErr_o <= 1'b0;
        end else if (flush_i) begin
            inflight <= '0;
            oldest_pid <= next_pid;
        end else begin
            inflight <= inflight + 3'(issue) - 3'(retire_ok);
            next_pid <= next_pid + pid_t'(issue);
            oldest_pid <= oldest_pid + pid_t'(retire_ok);
            retireErr_o <= retireErr_o | retire_bad;
        end
    end
endmodule

// File: tb/tb_ifu_issue_queue.sv
// tb_ifu_issue_queue: directed self-checking bench for ifu_issue_queue.
module tb_ifu_issue_queue;
    logic clk, rst_n, fetchValid_i, fetchReady_o, flush_i, valid_o, ready_i;
    logic retireValid_i, retireErr_o;
    logic [31:0] fetchInst_i, fetchAddr_i, inst_o, instAddr_o;
    logic [1:0] way0_pID_o, retirePid_i;
    logic [2:0] inflight_o;
    int passed = 0, total = 0;

    ifu_issue_queue dut (
        .clk(clk), .rst_n(rst_n), .fetchValid_i(fetchValid_i), .fetchInst_i(fetchInst_i),
        .fetchAddr_i(fetchAddr_i), .fetchReady_o(fetchReady_o), .flush_i(flush_i),
        .valid_o(valid_o), .inst_o(inst_o), .instAddr_o(instAddr_o), .way0_pID_o(way0_pID_o),
        .ready_i(ready_i), .retireValid_i(retireValid_i), .retirePid_i(retirePid_i),
        .inflight_o(inflight_o), .retireErr_o(retireErr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fetchValid_i = 0; fetchInst_i = 0; fetchAddr_i = 0; flush_i = 0;
        ready_i = 0; retireValid_i = 0; retirePid_i = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_word(input logic [31:0] i, input logic [31:0] a);
        fetchValid_i = 1'b1; fetchInst_i = i; fetchAddr_i = a;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({valid_o, fetchReady_o, inflight_o, retireErr_o, way0_pID_o} !== 8'b0100_0000) $display("FAIL reset_ctrl got v=%b fr=%b inf=%0d err=%b pid=%0d", valid_o, fetchReady_o, inflight_o, retireErr_o, way0_pID_o); else passed++;
        total++; if ({inst_o, instAddr_o} !== 64'h0) $display("FAIL reset_head got inst=%h addr=%h want 0", inst_o, instAddr_o); else passed++;
    endtask

    task automatic test_first_issue();
        do_reset();
        drive_word(32'h0000_0013, 32'h8000_0000); ready_i = 1;
        step();
        fetchValid_i = 0;
        total++; if ({valid_o, way0_pID_o} !== 3'b100) $display("FAIL first_valid got v=%b pid=%0d want v=1 pid=0", valid_o, way0_pID_o); else passed++;
        total++; if ({inst_o, instAddr_o} !== 64'h0000_0013_8000_0000) $display("FAIL first_head got inst=%h addr=%h", inst_o, instAddr_o); else passed++;
        step();
        total++; if ({valid_o, inflight_o} !== 4'b0001) $display("FAIL first_inflight got v=%b inf=%0d want v=0 inf=1", valid_o, inflight_o); else passed++;
    endtask

    task automatic test_full_hold();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive_word(32'hA000_0000 + k, 32'h8000_1000 + 4 * k);
            step();
        end
        total++; if (fetchReady_o !== 1'b0) $display("FAIL full_ready got %b want 0", fetchReady_o); else passed++;
        drive_word(32'hA000_0004, 32'h8000_1010);
        for (int c = 0; c < 10; c++) begin
            step();
            total++; if ({valid_o, way0_pID_o, fetchReady_o, inst_o, instAddr_o} !== {1'b1, 2'd0, 1'b0, 32'hA000_0000, 32'h8000_1000}) $display("FAIL hold_c%0d got v=%b pid=%0d fr=%b inst=%h addr=%h", c, valid_o, way0_pID_o, fetchReady_o, inst_o, instAddr_o); else passed++;
        end
        fetchValid_i = 0; ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            total++; if ({valid_o, way0_pID_o, inst_o} !== {1'b1, 2'(k), 32'hA000_0000 + k}) $display("FAIL drain_%0d got v=%b pid=%0d inst=%h", k, valid_o, way0_pID_o, inst_o); else passed++;
            step();
        end
        total++; if ({valid_o, inflight_o} !== 4'b0100) $display("FAIL drain_end got v=%b inf=%0d want v=0 inf=4", valid_o, inflight_o); else passed++;
        for (int k = 0; k < 4; k++) begin
            retireValid_i = 1; retirePid_i = 2'(k);
            step();
        end
        retireValid_i = 0;
        total++; if ({valid_o, inflight_o, fetchReady_o, retireErr_o} !== 6'b0_000_1_0) $display("FAIL fifth_dropped got v=%b inf=%0d fr=%b err=%b", valid_o, inflight_o, fetchReady_o, retireErr_o); else passed++;
    endtask

    task automatic test_inflight_limit();
        do_reset();
        ready_i = 1;
        for (int k = 0; k < 5; k++) begin
            drive_word(32'hB000_0000 + k, 32'h9000_0000 + 4 * k);
            step();
        end
        fetchValid_i = 0;
        total++; if ({valid_o, inflight_o, fetchReady_o} !== 5'b0_100_1) $display("FAIL limit_stall got v=%b inf=%0d fr=%b", valid_o, inflight_o, fetchReady_o); else passed++;
        retireValid_i = 1; retirePid_i = 0;
        step();
        retireValid_i = 0;
        total++; if ({valid_o, way0_pID_o, inflight_o, inst_o} !== {1'b1, 2'd0, 3'd3, 32'hB000_0004}) $display("FAIL limit_resume got v=%b pid=%0d inf=%0d inst=%h", valid_o, way0_pID_o, inflight_o, inst_o); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        ready_i = 1;
        for (int c = 0; c <= 22; c++) begin
            if (c >= 1 && c <= 20) begin
                total++; if ({valid_o, way0_pID_o, inst_o} !== {1'b1, 2'((c - 1) % 4), 32'h1000 + c - 1}) $display("FAIL b2b_issue_%0d got v=%b pid=%0d inst=%h", c, valid_o, way0_pID_o, inst_o); else passed++;
            end
            if (c >= 2 && c <= 21) begin
                total++; if (inflight_o !== 3'd1) $display("FAIL b2b_inflight_%0d got %0d want 1", c, inflight_o); else passed++;
            end
            fetchValid_i = c < 20; fetchInst_i = 32'h1000 + c; fetchAddr_i = 32'h4000_0000 + 4 * c;
            retireValid_i = c >= 2 && c <= 21; retirePid_i = 2'((c - 2) % 4);
            if (c < 22) step();
        end
        total++; if ({inflight_o, retireErr_o, valid_o} !== 5'b0) $display("FAIL b2b_end got inf=%0d err=%b v=%b", inflight_o, retireErr_o, valid_o); else passed++;
    endtask

    task automatic test_flush();
        do_reset();
        drive_word(32'hC000_0000, 32'hC0); step();
        drive_word(32'hC000_0001, 32'hC4); step();
        drive_word(32'hC000_0002, 32'hC8); ready_i = 1; step();
        drive_word(32'hC000_0003, 32'hCC); step();
        drive_word(32'hC000_0004, 32'hD0); ready_i = 0; step();
        total++; if ({valid_o, way0_pID_o, inflight_o, inst_o} !== {1'b1, 2'd2, 3'd2, 32'hC000_0002}) $display("FAIL preflush got v=%b pid=%0d inf=%0d inst=%h", valid_o, way0_pID_o, inflight_o, inst_o); else passed++;
        flush_i = 1; drive_word(32'hC000_0005, 32'hD4); ready_i = 1; retireValid_i = 1; retirePid_i = 0;
        step();
        flush_i = 0; ready_i = 0; retireValid_i = 0;
        total++; if ({valid_o, inflight_o, fetchReady_o, retireErr_o} !== 6'b0_000_1_0) $display("FAIL postflush got v=%b inf=%0d fr=%b err=%b", valid_o, inflight_o, fetchReady_o, retireErr_o); else passed++;
        drive_word(32'hC000_0006, 32'hD8); step();
        fetchValid_i = 0;
        total++; if ({valid_o, way0_pID_o, inst_o} !== {1'b1, 2'd2, 32'hC000_0006}) $display("FAIL flush_pid got v=%b pid=%0d inst=%h", valid_o, way0_pID_o, inst_o); else passed++;
        ready_i = 1; step(); ready_i = 0;
        total++; if ({valid_o, inflight_o} !== 4'b0001) $display("FAIL flush_empty got v=%b inf=%0d want v=0 inf=1", valid_o, inflight_o); else passed++;
        retireValid_i = 1; retirePid_i = 2; step(); retireValid_i = 0;
        total++; if ({inflight_o, retireErr_o} !== 4'b0) $display("FAIL flush_retire got inf=%0d err=%b", inflight_o, retireErr_o); else passed++;
    endtask

    task automatic test_retire_err();
        do_reset();
        retireValid_i = 1; retirePid_i = 0; step(); retireValid_i = 0;
        total++; if ({retireErr_o, inflight_o} !== 4'b1_000) $display("FAIL underflow got err=%b inf=%0d", retireErr_o, inflight_o); else passed++;
        do_reset();
        drive_word(32'hD000_0000, 32'hE0); ready_i = 1; step();
        fetchValid_i = 0; step(); ready_i = 0;
        total++; if ({retireErr_o, inflight_o} !== 4'b0_001) $display("FAIL mismatch_pre got err=%b inf=%0d", retireErr_o, inflight_o); else passed++;
        retireValid_i = 1; retirePid_i = 2; step(); retireValid_i = 0;
        total++; if ({retireErr_o, inflight_o} !== 4'b1_000) $display("FAIL mismatch got err=%b inf=%0d", retireErr_o, inflight_o); else passed++;
        drive_word(32'hD000_0001, 32'hE4);
        for (int c = 0; c < 3; c++) begin
            step();
            fetchValid_i = 0;
            total++; if (retireErr_o !== 1'b1) $display("FAIL err_sticky_%0d got %b want 1", c, retireErr_o); else passed++;
        end
        total++; if ({valid_o, way0_pID_o, inst_o} !== {1'b1, 2'd1, 32'hD000_0001}) $display("FAIL pre_async got v=%b pid=%0d inst=%h", valid_o, way0_pID_o, inst_o); else passed++;
        #2 rst_n = 0;
        #1;
        total++; if ({valid_o, way0_pID_o, inflight_o, retireErr_o, fetchReady_o, inst_o, instAddr_o} !== {1'b0, 2'd0, 3'd0, 1'b0, 1'b1, 64'h0}) $display("FAIL async_reset got v=%b pid=%0d inf=%0d err=%b fr=%b inst=%h addr=%h", valid_o, way0_pID_o, inflight_o, retireErr_o, fetchReady_o, inst_o, instAddr_o); else passed++;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_first_issue();
        test_full_hold();
        test_inflight_limit();
        test_back_to_back();
        test_flush();
        test_retire_err();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ifu_issue_queue.md
# ifu_issue_queue

Instruction issue queue at the IFU end of the fetch→decode interface. It is the transmitter that drives the way0 decoder's `valid`/`inst`/`instAddr`/`pID` inputs and consumes its `ready`. Fetched words are buffered in a small FIFO, and each issued instruction gets a rotating 2-bit packet ID (pID). Outstanding pIDs are tracked until the downstream pipeline retires them. The queue is emptied on a front-end redirect (flush).

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `MAX_INFLIGHT`, 4: issued-but-unretired limit; must be ≤4 (pID space).

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `fetchValid_i`  in  1  fetch response word valid
- `fetchInst_i`  in  32  fetched instruction
- `fetchAddr_i`  in  32  its PC
- `fetchReady_o`  out  1  queue can accept a word this cycle
- `flush_i`  in  1  redirect: discard queue and in-flight tracking
- `valid_o`  out  1  instruction presented to decoder
- `inst_o`  out  32  head instruction
- `instAddr_o`  out  32  head PC
- `way0_pID_o`  out  2  pID of the presented instruction
- `ready_i`  in  1  decoder/DU register accepts
- `retireValid_i`  in  1  one instruction retired
- `retirePid_i`  in  2  pID being retired
- `inflight_o`  out  3  current outstanding count
- `retireErr_o`  out  1  sticky: retire mismatch or underflow

## Operation
- Push: `fetchValid_i && fetchReady_o` writes {inst, addr} at the tail.
- `fetchReady_o = (count != DEPTH)`. It depends only on registered count; there is no same-cycle bypass at full.
- Issue condition: `valid_o = (count != 0) && (inflight < MAX_INFLIGHT)`. An issue occurs on `valid_o && ready_i`.
- On issue: pop the head, then increment `nextPid` (wraps 3→0) and `inflight`.
- `way0_pID_o = nextPid` whenever `valid_o` is high.
- While `valid_o && !ready_i`, `inst_o`, `instAddr_o` and `way0_pID_o` hold stable.
- Retire: `retireValid_i` decrements `inflight`. Retirement is in order, so `retirePid_i` must equal `oldestPid`; on success `oldestPid` is incremented (wraps).
  - Mismatch: still decrements and advances, and sets `retireErr_o`.
  - With `inflight==0`: ignored, and sets `retireErr_o`.
  - `retireErr_o` clears only on reset.
- Issue and retire in the same cycle: `inflight` unchanged; both pointers advance.
- Push and pop in the same cycle with 0<count<DEPTH: count unchanged. At count==0, a push is not poppable in the same cycle.
- Flush has priority over push, issue and retire in that cycle:
  - count←0 and inflight←0; read and write pointers are equal.
  - `oldestPid←nextPid`. `nextPid` is not reset, so post-flush IDs continue the sequence.
  - `retireErr_o` is unaffected.
- Reset (async, mid-operation included) values:
  - count, inflight, pointers, `nextPid`, `oldestPid`, `retireErr_o` = 0.
  - Storage = 0.
  - Outputs: `valid_o=0`, `inst_o=0`, `instAddr_o=0`, `way0_pID_o=0`, `inflight_o=0`, `retireErr_o=0`, `fetchReady_o=1`.

## Timing
- Fetch-to-present latency is 1 cycle: a word pushed at edge N is on `inst_o` with `valid_o=1` after edge N (cycle N+1), if no older entries and the inflight limit is not reached.
- Throughput is 1 issue/cycle with continuous push and retire.
- Head outputs come from registered storage and pointers. `valid_o` and `fetchReady_o` come from registered state only, with no combinational path from `ready_i`/`fetchValid_i`.
- Retire frees a slot the cycle after the retire edge. Retire at edge N with inflight==MAX allows `valid_o` during cycle N+1.
- After flush at edge N: cycle N+1 has `valid_o=0` and `fetchReady_o=1`. A word pushed in cycle N+1 presents in N+2.

## Structure
- Shared package `b8_ifu_pkg` holds:
  - `pid_t` (logic [1:0]);
  - `issue_entry_t` struct {inst[31:0], addr[31:0]};
  - `ISSUE_DEPTH` and `MAX_INFLIGHT` constants.
- Sub-module `SyncFifo`: parameterised width/depth, pointer-plus-extra-bit full/empty, push/pop/clear ports, async active-low reset.
- Top level holds the pID counters, the inflight counter and error logic.

## Test plan
- Reset, then push 0x00000013@0x80000000 with `ready_i=1` → next cycle `valid_o=1`, `way0_pID_o=0`, `instAddr_o=0x80000000`; one cycle later `inflight_o=1`.
- Push 4 words with `ready_i=0` → `fetchReady_o=0` at count 4. A 5th `fetchValid_i` is not accepted. Head holds the first word stably for 10 cycles.
- Issue 4 without retire → `valid_o` drops with queue non-empty. Retire pID 0 → `valid_o` is back 1 cycle later with `way0_pID_o=0` (wrapped).
- Simultaneous issue and retire each cycle over 20 instructions → `inflight_o` constant, pIDs sequence 0,1,2,3,0,…, no `retireErr_o`.
- Flush with 3 queued and 2 in flight plus a same-cycle push → next cycle count 0, `inflight_o=0`, `valid_o=0`. The next issued pID continues from the pre-flush `nextPid`.
- Retire pID 2 when oldest is 0 → `retireErr_o=1`, staying high until `rst_n` asserts. Retire with `inflight_o=0` → `retireErr_o=1`, `inflight_o` stays 0.
